// File: rtl/skip_adder_seq.sv
// skip_adder_seq: multi-cycle carry-skip adder resolving one BLOCK-bit group per clock.
// Each group's group-propagate selects between the bypassed group carry-in and
// the ripple carry out of the group's top bit.
// Optional feature: define SKIP_STATS_EN to build the skipped-group counter;
// otherwise skipcount_o is tied to 0.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | resolving group idx_q, one per cycle
// DONE  | result valid, done_o pulses; a new start_i may be accepted
module skip_adder_seq #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carryin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carryout_o,
    output logic [7:0]       skipcount_o
);

    localparam int G = WIDTH / BLOCK;
    localparam logic [7:0] LAST_IDX = 8'(G - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic             carry_q;
    logic             cout_q;
    logic [7:0]       idx_q;

    logic             accept;
    logic             run_step;
    logic             last_grp;
    int               sh;
    logic [BLOCK-1:0] ga, gb, gp, gs;
    logic             c;
    logic             p_all;
    logic             ripple_co;
    logic             grp_co;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; start_i is only looked at outside RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_grp) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy_o   = (state_q == RUN);
        done_o   = (state_q == DONE);
        accept   = start_i && ((state_q == IDLE) || (state_q == DONE));
        run_step = (state_q == RUN);
        last_grp = (idx_q == LAST_IDX);
    end

    // Resolve the current group: ripple through its bits, then skip-mux the carry
    always_comb begin
        sh    = int'(idx_q) * BLOCK;
        ga    = BLOCK'(a_q >> sh);
        gb    = BLOCK'(b_q >> sh);
        gp    = '0;
        gs    = '0;
        c     = carry_q;
        p_all = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            gp[i] = ga[i] ^ gb[i];
            gs[i] = gp[i] ^ c;
            c     = (ga[i] & gb[i]) | (gp[i] & c);
            p_all = p_all & gp[i];
        end
        ripple_co = c;
        // Arithmetically equal to ripple_co; the bypass path is the point of the structure
        grp_co    = p_all ? carry_q : ripple_co;
        sum_d     = sum_q;
        sum_d[sh +: BLOCK] = gs;
    end

    // Operand capture and per-group result accumulation
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= carryin_i;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (run_step) begin
            sum_q   <= sum_d;
            carry_q <= grp_co;
            if (last_grp) cout_q <= grp_co;
            else          idx_q  <= 8'(idx_q + 8'd1);
        end
    end

`ifdef SKIP_STATS_EN
    logic [7:0] skip_q;

    // Saturating count of groups that took the bypass path
    always_ff @(posedge clk_i) begin
        if (reset_i)                                    skip_q <= '0;
        else if (accept)                                skip_q <= '0;
        else if (run_step && p_all && skip_q != 8'hFF)  skip_q <= 8'(skip_q + 8'd1);
    end

    assign skipcount_o = skip_q;
`else
    assign skipcount_o = 8'd0;
`endif

    assign sum_o      = sum_q;
    assign carryout_o = cout_q;

endmodule

// File: tb/tb_skip_adder_seq.sv
// Testbench for skip_adder_seq (WIDTH=16, BLOCK=4): table-driven vectors plus
// hand-written sequences for ignored start, mid-run reset and back-to-back runs.
module tb_skip_adder_seq;

    localparam int WIDTH = 16;
    localparam int G     = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             busy, done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [7:0]       skipcnt;

    int total = 0;
    int bad   = 0;

    skip_adder_seq #(.WIDTH(WIDTH), .BLOCK(4)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .a_i         (a),
        .b_i         (b),
        .carryin_i   (cin),
        .busy_o      (busy),
        .done_o      (done),
        .sum_o       (sum),
        .carryout_o  (cout),
        .skipcount_o (skipcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic [7:0]  skip;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [7:0] exp_skip(input logic [7:0] s);
`ifdef SKIP_STATS_EN
        return s;
`else
        return 8'd0 & s;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for done; returns edges counted, or -1 if none within the budget
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            n++;
            if (done) return;
        end
        n = -1;
    endtask

    task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic [15:0] es, input logic ec,
                          input logic [7:0] ek);
        int n;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, " busy after accept"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({name, " latency"}, 32'(n), 32'(G));
        chk({name, " sum"}, 32'(sum), 32'(es));
        chk({name, " carryout"}, 32'(cout), 32'(ec));
        chk({name, " skipcount"}, 32'(skipcnt), 32'(exp_skip(ek)));
        chk({name, " busy in done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({name, " done single"}, 32'(done), 32'd0);
        chk({name, " sum held"}, 32'(sum), 32'(es));
    endtask

    initial begin
        int n;
        int seen;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 8'd1};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 8'd4};
        vecs[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 8'd0};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 8'd3};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 8'd0};
        vecs[5] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 8'd4};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 8'd0};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 8'd2};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset carryout", 32'(cout), 32'd0);
        chk("reset skipcount", 32'(skipcnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, vecs[i].skip);

        // Second start during RUN must be ignored
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignored start busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("ignored start latency", 32'(n), 32'(G - 2));
        chk("ignored start sum", 32'(sum), 32'h0000);
        chk("ignored start carryout", 32'(cout), 32'd1);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("ignored start no second run", 32'(seen), 32'd0);

        // Reset in RUN cycle 2 discards the operation
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("partial sum before reset", 32'(sum), 32'h0005);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrun reset busy", 32'(busy), 32'd0);
        chk("midrun reset done", 32'(done), 32'd0);
        chk("midrun reset sum", 32'(sum), 32'd0);
        chk("midrun reset carryout", 32'(cout), 32'd0);
        chk("midrun reset skipcount", 32'(skipcnt), 32'd0);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("midrun reset no done", 32'(seen), 32'd0);
        run_op("after reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 8'd1);

        // Back-to-back with start held high
        @(negedge clk);
        a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        chk("b2b first latency", 32'(n), 32'(G));
        chk("b2b sum 0", 32'(sum), 32'h0000);
        chk("b2b carryout 0", 32'(cout), 32'd1);
        chk("b2b skipcount 0", 32'(skipcnt), 32'd0);
        for (int r = 1; r < 4; r++) begin
            wait_done(n);
            chk($sformatf("b2b period %0d", r), 32'(n), 32'(G + 1));
            chk($sformatf("b2b sum %0d", r), 32'(sum), 32'h0000);
            chk($sformatf("b2b carryout %0d", r), 32'(cout), 32'd1);
            chk($sformatf("b2b skipcount %0d", r), 32'(skipcnt), 32'd0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b idle after release", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
